wb_port_sched: RTL and testbench

- Write-back scheduler for the SEQ register file: 15 64-bit registers, ID 0xF = RNONE.
- Accepts one write-back bundle per instruction (dstE/valE, dstM/valM) and sequences it onto the file's single write port, E first then M.
- Resolves the dstE==dstM conflict in favour of M (popq %rsp semantics).
- Flags decode read hazards against the in-flight bundle so the front end can stall.

---
 rtl/y86_pkg.sv | 34 +++
 rtl/wb_port_sched.sv | 122 ++++++++++++
 tb/tb_wb_port_sched.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: register IDs, datapath widths and the write-back state encoding.
// Reused by the decode block, the register file and the write-back scheduler.
package y86_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 64;

  typedef logic [ADDR_W-1:0] reg_id_t;

  localparam reg_id_t RAX   = 4'h0;
  localparam reg_id_t RCX   = 4'h1;
  localparam reg_id_t RDX   = 4'h2;
  localparam reg_id_t RBX   = 4'h3;
  localparam reg_id_t RSP   = 4'h4;
  localparam reg_id_t RBP   = 4'h5;
  localparam reg_id_t RSI   = 4'h6;
  localparam reg_id_t RDI   = 4'h7;
  localparam reg_id_t R8    = 4'h8;
  localparam reg_id_t R9    = 4'h9;
  localparam reg_id_t R10   = 4'hA;
  localparam reg_id_t R11   = 4'hB;
  localparam reg_id_t R12   = 4'hC;
  localparam reg_id_t R13   = 4'hD;
  localparam reg_id_t R14   = 4'hE;
  localparam reg_id_t RNONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_E = 2'd1,
    WR_M = 2'd2,
    SKIP = 2'd3
  } wb_state_t;

endpackage

// File: rtl/wb_port_sched.sv
// Sequences one (dstE/valE, dstM/valM) write-back bundle onto the single register-file
// write port, E before M, and flags decode reads that hit a still-pending write.
module wb_port_sched #(
  parameter int                DATA_W = y86_pkg::DATA_W,
  parameter int                ADDR_W = y86_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RNONE  = y86_pkg::RNONE,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_dstE,
  input  logic [DATA_W-1:0] wb_valE,
  input  logic [ADDR_W-1:0] wb_dstM,
  input  logic [DATA_W-1:0] wb_valM,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_done,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic              hazard,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  wr_count
);
  import y86_pkg::*;

  wb_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] dste_reg, dstm_reg;
  logic [DATA_W-1:0] vale_reg, valm_reg;
  logic              need_e_reg, need_m_reg;
  logic [CNT_W-1:0]  wr_count_reg;

  logic accept;
  logic need_e_in, need_m_in;

  // When both destinations collide, M wins and the E write is dropped (popq %rsp).
  assign need_m_in = (wb_dstM != RNONE);
  assign need_e_in = (wb_dstE != RNONE) && (wb_dstE != wb_dstM);
  assign accept    = wb_valid && wb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      dste_reg     <= RNONE;
      dstm_reg     <= RNONE;
      vale_reg     <= '0;
      valm_reg     <= '0;
      need_e_reg   <= 1'b0;
      need_m_reg   <= 1'b0;
      wr_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        dste_reg   <= wb_dstE;
        dstm_reg   <= wb_dstM;
        vale_reg   <= wb_valE;
        valm_reg   <= wb_valM;
        need_e_reg <= need_e_in;
        need_m_reg <= need_m_in;
      end
      if (cnt_clr) begin
        wr_count_reg <= '0;
      end else if (rf_we) begin
        wr_count_reg <= wr_count_reg + 1'b1;
      end
    end
  end

  assign wr_count = wr_count_reg;

  function automatic logic id_hit(input logic [ADDR_W-1:0] p,
                                  input logic [ADDR_W-1:0] a,
                                  input logic [ADDR_W-1:0] b);
    return (p != RNONE) && ((a == p) || (b == p));
  endfunction

  always_comb begin
    state_next = state_reg;
    wb_ready   = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = RNONE;
    rf_wdata   = '0;
    wb_done    = 1'b0;
    hazard     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        wb_ready = 1'b1;
        if (accept) begin
          if (need_e_in)      state_next = WR_E;
          else if (need_m_in) state_next = WR_M;
          else                state_next = SKIP;
        end
      end
      WR_E: begin
        rf_we      = 1'b1;
        rf_waddr   = dste_reg;
        rf_wdata   = vale_reg;
        wb_done    = !need_m_reg;
        hazard     = (need_e_reg && id_hit(dste_reg, srcA, srcB)) ||
                     (need_m_reg && id_hit(dstm_reg, srcA, srcB));
        state_next = need_m_reg ? WR_M : IDLE;
      end
      WR_M: begin
        rf_we      = 1'b1;
        rf_waddr   = dstm_reg;
        rf_wdata   = valm_reg;
        wb_done    = 1'b1;
        hazard     = id_hit(dstm_reg, srcA, srcB);
        state_next = IDLE;
      end
      SKIP: begin
        wb_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_port_sched.sv
// Randomized self-checking bench for wb_port_sched against a per-bundle write-list model.
module tb_wb_port_sched;

  localparam logic [3:0] RN = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready, wb_ready_w;
  logic [3:0]  wb_dstE, wb_dstM;
  logic [63:0] wb_valE, wb_valM;
  logic        rf_we, rf_we_w;
  logic [3:0]  rf_waddr, rf_waddr_w;
  logic [63:0] rf_wdata, rf_wdata_w;
  logic        wb_done, wb_done_w;
  logic [3:0]  srcA, srcB;
  logic        hazard, hazard_w;
  logic        cnt_clr;
  logic [15:0] wr_count;
  logic [3:0]  wr_count_w;

  int n_checks = 0;
  int n_err    = 0;
  int cnt_m    = 0;
  int cntw_m   = 0;

  always #5 clk = ~clk;

  wb_port_sched dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_done(wb_done),
    .srcA(srcA), .srcB(srcB), .hazard(hazard), .cnt_clr(cnt_clr), .wr_count(wr_count)
  );

  // Narrow-counter copy so counter wrap is reached in a short run.
  wb_port_sched #(.CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready_w),
    .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
    .rf_we(rf_we_w), .rf_waddr(rf_waddr_w), .rf_wdata(rf_wdata_w), .wb_done(wb_done_w),
    .srcA(srcA), .srcB(srcB), .hazard(hazard_w), .cnt_clr(cnt_clr), .wr_count(wr_count_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_counts();
    check("wr_count", {48'd0, wr_count}, 64'(cnt_m));
    check("wr_count_w", {60'd0, wr_count_w}, 64'(cntw_m));
  endtask

  function automatic logic [3:0] pick_src(input logic [3:0] e, input logic [3:0] m);
    case ($urandom % 4)
      0:       return RN;
      1:       return 4'($urandom);
      2:       return e;
      default: return m;
    endcase
  endfunction

  function automatic logic [3:0] rand_dst();
    return ($urandom % 4 == 0) ? RN : 4'($urandom % 15);
  endfunction

  // Called just after a falling edge with the scheduler idle.
  task automatic run_bundle(input logic [3:0] de, input logic [63:0] ve,
                            input logic [3:0] dm, input logic [63:0] vm,
                            input bit rnd, input logic [3:0] sa, input logic [3:0] sb,
                            input bit force_clr);
    logic [3:0]  wa[$];
    logic [63:0] wd[$];
    int          n;
    bit          clr, we, hz;
    logic [3:0]  a, b;

    // Expected write list: E then M, with E dropped when it would be overwritten by M.
    if (de != RN && de != dm) begin wa.push_back(de); wd.push_back(ve); end
    if (dm != RN)             begin wa.push_back(dm); wd.push_back(vm); end
    n = (wa.size() == 0) ? 1 : wa.size();

    srcA    = rnd ? 4'($urandom) : sa;
    srcB    = rnd ? 4'($urandom) : sb;
    clr     = rnd && ($urandom % 8 == 0);
    cnt_clr = clr;
    #1;
    check("idle_ready", {63'd0, wb_ready}, 64'd1);
    check("idle_we", {63'd0, rf_we}, 64'd0);
    check("idle_waddr", {60'd0, rf_waddr}, {60'd0, RN});
    check("idle_wdata", rf_wdata, 64'd0);
    check("idle_done", {63'd0, wb_done}, 64'd0);
    check("idle_hazard", {63'd0, hazard}, 64'd0);
    check_counts();
    wb_valid = 1'b1;
    wb_dstE  = de;
    wb_valE  = ve;
    wb_dstM  = dm;
    wb_valM  = vm;
    @(posedge clk);
    if (clr) begin cnt_m = 0; cntw_m = 0; end
    @(negedge clk);

    for (int k = 0; k < n; k++) begin
      // Busy cycles: a held-high wb_valid with fresh fields must be ignored.
      wb_valid = rnd ? 1'($urandom % 2) : 1'b0;
      if (rnd) begin
        wb_dstE = rand_dst();
        wb_dstM = rand_dst();
        wb_valE = {$urandom, $urandom};
        wb_valM = {$urandom, $urandom};
      end
      a       = rnd ? pick_src(de, dm) : sa;
      b       = rnd ? pick_src(de, dm) : sb;
      srcA    = a;
      srcB    = b;
      clr     = force_clr || (rnd && ($urandom % 8 == 0));
      cnt_clr = clr;
      #1;
      we = (wa.size() > 0);
      hz = 1'b0;
      for (int j = k; j < wa.size(); j++)
        if (wa[j] == a || wa[j] == b) hz = 1'b1;
      check("busy_ready", {63'd0, wb_ready}, 64'd0);
      check("rf_we", {63'd0, rf_we}, {63'd0, we});
      check("rf_waddr", {60'd0, rf_waddr}, {60'd0, (we ? wa[k] : RN)});
      check("rf_wdata", rf_wdata, we ? wd[k] : 64'd0);
      check("wb_done", {63'd0, wb_done}, {63'd0, (k == n - 1)});
      check("hazard", {63'd0, hazard}, {63'd0, hz});
      check_counts();
      @(posedge clk);
      cnt_m  = clr ? 0 : ((cnt_m + int'(we)) & 16'hFFFF);
      cntw_m = clr ? 0 : ((cntw_m + int'(we)) & 4'hF);
      @(negedge clk);
    end
    wb_valid = 1'b0;
    cnt_clr  = 1'b0;
    $display("bundle dstE=%h valE=%h dstM=%h valM=%h writes=%0d count=%0d",
             de, ve, dm, vm, wa.size(), cnt_m);
  endtask

  initial begin
    rst_n    = 1'b0;
    wb_valid = 1'b0;
    wb_dstE  = RN;
    wb_dstM  = RN;
    wb_valE  = '0;
    wb_valM  = '0;
    srcA     = 4'h1;
    srcB     = 4'h2;
    cnt_clr  = 1'b0;
    #2;
    check("rst_ready", {63'd0, wb_ready}, 64'd1);
    check("rst_we", {63'd0, rf_we}, 64'd0);
    check("rst_waddr", {60'd0, rf_waddr}, {60'd0, RN});
    check("rst_wdata", rf_wdata, 64'd0);
    check("rst_done", {63'd0, wb_done}, 64'd0);
    check("rst_hazard", {63'd0, hazard}, 64'd0);
    check_counts();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_bundle(4'h3, 64'h55, RN, 64'h0, 1'b0, RN, RN, 1'b0);
    run_bundle(4'h0, 64'hA, 4'h1, 64'hB, 1'b0, 4'h1, RN, 1'b0);
    run_bundle(4'h0, 64'hA, 4'h1, 64'hB, 1'b0, 4'h0, RN, 1'b0);
    run_bundle(4'h0, 64'hA, 4'h1, 64'hB, 1'b0, RN, RN, 1'b0);
    run_bundle(4'h4, 64'h100, 4'h4, 64'h200, 1'b0, 4'h4, RN, 1'b0);
    run_bundle(RN, 64'h1, RN, 64'h2, 1'b0, RN, RN, 1'b0);
    run_bundle(4'h2, 64'h7, 4'h5, 64'h9, 1'b0, 4'h2, 4'h5, 1'b1);

    // Reset in the first write cycle of a two-write bundle.
    srcA     = 4'h1;
    srcB     = RN;
    wb_valid = 1'b1;
    wb_dstE  = 4'h0;
    wb_valE  = 64'hA;
    wb_dstM  = 4'h1;
    wb_valM  = 64'hB;
    @(posedge clk);
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    check("mid_we", {63'd0, rf_we}, 64'd1);
    check("mid_wdata", rf_wdata, 64'hA);
    rst_n = 1'b0;
    #1;
    cnt_m  = 0;
    cntw_m = 0;
    check("arst_we", {63'd0, rf_we}, 64'd0);
    check("arst_waddr", {60'd0, rf_waddr}, {60'd0, RN});
    check("arst_wdata", rf_wdata, 64'd0);
    check("arst_done", {63'd0, wb_done}, 64'd0);
    check("arst_hazard", {63'd0, hazard}, 64'd0);
    check_counts();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {63'd0, wb_ready}, 64'd1);
    check("post_rst_we", {63'd0, rf_we}, 64'd0);
    check_counts();
    @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] de, dm;
      de = rand_dst();
      dm = ($urandom % 5 == 0) ? de : rand_dst();
      if ($urandom % 3 == 0) @(negedge clk);
      run_bundle(de, {$urandom, $urandom}, dm, {$urandom, $urandom}, 1'b1, RN, RN, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
